// File: rtl/ram_line_bridge.sv
// ram_line_bridge: single-outstanding bridge from the cache miss path to the
// word-organised line RAM. It turns a byte address into a line-aligned RAM
// word index, issues one read or write per transaction, and returns the
// result on a response port that holds its value until it is accepted.
//
// Optional feature macro: RAM_BRIDGE_RANGE_CHECK_EN
//   defined   : addresses outside [BASE_ADDR, BASE_ADDR + RAM_DEPTH*4) get
//               rsp_err_o=1 and cause no RAM access
//   undefined : every address is in range, the index wraps modulo RAM_DEPTH,
//               and rsp_err_o is always 0
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake
//   req_we_i                  1 = write line, 0 = read line
//   req_addr_i                byte address (bits below the line size ignored)
//   req_wdata_i/req_wstrb_i   write line and byte enables
//   rsp_valid_o/rsp_ready_i   response handshake (held until accepted)
//   rsp_rdata_o, rsp_err_o    read line (0 for writes/errors), range error
//   prog_busy_i               UART programmer owns the RAM; blocks new requests
//   ram_addr_o                line-aligned word index
//   ram_wdata_o/ram_wstrb_o   write line and strobes to the RAM
//   ram_rd_en_o               one-cycle read enable
//   ram_rdata_i               registered RAM read line
module ram_line_bridge #(
    parameter int unsigned BLK_SIZE  = 128,
    parameter int unsigned RAM_DEPTH = 32768,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_we_i,
    input  logic [31:0]                  req_addr_i,
    input  logic [BLK_SIZE-1:0]          req_wdata_i,
    input  logic [BLK_SIZE/8-1:0]        req_wstrb_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [BLK_SIZE-1:0]          rsp_rdata_o,
    output logic                         rsp_err_o,
    input  logic                         prog_busy_i,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addr_o,
    output logic [BLK_SIZE-1:0]          ram_wdata_o,
    output logic [BLK_SIZE/8-1:0]        ram_wstrb_o,
    output logic                         ram_rd_en_o,
    input  logic [BLK_SIZE-1:0]          ram_rdata_i
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);
    localparam int unsigned SW = BLK_SIZE / 8;
    localparam int unsigned LW = $clog2(BLK_SIZE / 32);
    // Clears the word-within-line bits so the index always points at a line start.
    localparam logic [AW-1:0] LINE_MASK = ~AW'((1 << LW) - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t              state;
    logic [BLK_SIZE-1:0] rdata_q;
    logic                err_q;
    logic [31:0]         offset;
    logic                in_range;
    logic                fire;
    logic                unused_offset;

    // Byte offset from RAM base; only the word-index bits reach the RAM.
    assign offset        = req_addr_i - BASE_ADDR;
    assign unused_offset = ^offset;
    assign ram_addr_o    = AW'(offset >> 2) & LINE_MASK;

`ifdef RAM_BRIDGE_RANGE_CHECK_EN
    localparam logic [32:0] RANGE_LO = 33'(BASE_ADDR);
    localparam logic [32:0] RANGE_HI = RANGE_LO + (33'(RAM_DEPTH) << 2);

    // 33-bit compare so a window ending at 4 GiB does not wrap.
    assign in_range = ({1'b0, req_addr_i} >= RANGE_LO) &&
                      ({1'b0, req_addr_i} <  RANGE_HI);
`else
    assign in_range = 1'b1;
`endif

    // Request handshake and RAM pin drive.
    assign req_ready_o = (state == IDLE) && !prog_busy_i;
    assign fire        = req_valid_i && req_ready_o;
    assign ram_wdata_o = req_wdata_i;
    // RAM strobes stay quiet while reset is asserted, even if a request is presented.
    assign ram_rd_en_o = rst_ni && fire && !req_we_i && in_range;
    assign ram_wstrb_o = (rst_ni && fire && req_we_i && in_range) ? req_wstrb_i : SW'(0);

    // Response port driven straight from registers.
    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // Transaction FSM with the response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        rdata_q <= '0;
                        err_q   <= !in_range;
                        if (in_range && !req_we_i) begin
                            state <= RD_WAIT;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RD_WAIT: begin
                    rdata_q <= ram_rdata_i;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_line_bridge.sv
// Directed bench for ram_line_bridge with a behavioural line RAM and a
// response scoreboard queue.
module tb_ram_line_bridge;

    localparam int unsigned BLK   = 128;
    localparam int unsigned DEPTH = 32768;
    localparam int unsigned AW    = 15;
    localparam int unsigned SW    = BLK / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [31:0]     req_addr;
    logic [BLK-1:0]  req_wdata;
    logic [SW-1:0]   req_wstrb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BLK-1:0]  rsp_rdata;
    logic            rsp_err;
    logic            prog_busy;
    logic [AW-1:0]   ram_addr;
    logic [BLK-1:0]  ram_wdata;
    logic [SW-1:0]   ram_wstrb;
    logic            ram_rd_en;
    logic [BLK-1:0]  ram_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [BLK-1:0] rdata;
        logic           err;
    } rsp_t;

    rsp_t exp_q[$];

    ram_line_bridge #(
        .BLK_SIZE (BLK),
        .RAM_DEPTH(DEPTH),
        .BASE_ADDR(32'h8000_0000)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .prog_busy_i(prog_busy),
        .ram_addr_o (ram_addr),
        .ram_wdata_o(ram_wdata),
        .ram_wstrb_o(ram_wstrb),
        .ram_rd_en_o(ram_rd_en),
        .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // Power-on RAM image: words 4..7 hold 11111111..44444444, others C0DE_<index>.
    function automatic logic [31:0] init_word(input int i);
        if (i >= 4 && i <= 7) return 32'h1111_1111 * 32'(i - 3);
        return {16'hC0DE, 16'(i)};
    endfunction

    function automatic logic [BLK-1:0] init_line(input int i);
        return {init_word(i + 3), init_word(i + 2), init_word(i + 1), init_word(i)};
    endfunction

    // Behavioural line RAM: registered read, byte-strobed write, reloaded in reset.
    logic [31:0] mem [DEPTH];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
        end else begin
            if (ram_rd_en) begin
                ram_rdata <= {mem[ram_addr + AW'(3)], mem[ram_addr + AW'(2)],
                              mem[ram_addr + AW'(1)], mem[ram_addr]};
            end
            for (int b = 0; b < int'(SW); b++) begin
                if (ram_wstrb[b]) mem[ram_addr + AW'(b / 4)][8 * (b % 4) +: 8] <= ram_wdata[8 * b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bail(input string tag);
        $display("FAIL %s bound expired", tag);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "bench stopped");
    endtask

    // Present one request from a post-edge point, check the fire-cycle RAM pins,
    // push the expected response. Returns one cycle later (post-edge).
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [BLK-1:0] wd, input logic [SW-1:0] ws,
                          input logic [AW-1:0] exp_idx, input logic exp_rd,
                          input logic [SW-1:0] exp_ws, input logic [BLK-1:0] exp_rdata,
                          input logic exp_err);
        rsp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        @(negedge clk);
        check({tag, ".ready"}, BLK'(req_ready), BLK'(1'b1));
        check({tag, ".no_rsp"}, BLK'(rsp_valid), BLK'(1'b0));
        if (!req_ready) bail({tag, ".accept"});
        check({tag, ".ram_addr"}, BLK'(ram_addr), BLK'(exp_idx));
        check({tag, ".rd_en"}, BLK'(ram_rd_en), BLK'(exp_rd));
        check({tag, ".wstrb"}, BLK'(ram_wstrb), BLK'(exp_ws));
        if (we) check({tag, ".wdata"}, ram_wdata, wd);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wstrb = '0;
    endtask

    // Wait for the response (entered post-edge in cycle 1), check latency and
    // payload against the scoreboard, optionally stall the consumer for `hold`
    // extra cycles. Returns post-edge in the cycle after acceptance.
    task automatic wait_rsp(input string tag, input int exp_lat, input int hold);
        int   n;
        rsp_t e;
        n = 1;
        rsp_ready = (hold == 0);
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            check({tag, ".quiet_rd_en"}, BLK'(ram_rd_en), BLK'(1'b0));
            check({tag, ".quiet_wstrb"}, BLK'(ram_wstrb), BLK'(0));
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
        end
        if (!rsp_valid) bail({tag, ".rsp"});
        check({tag, ".latency"}, BLK'(n), BLK'(exp_lat));
        if (exp_q.size() == 0) bail({tag, ".queue"});
        e = exp_q.pop_front();
        check({tag, ".rdata"}, rsp_rdata, e.rdata);
        check({tag, ".err"}, BLK'(rsp_err), BLK'(e.err));
        check({tag, ".ready_in_resp"}, BLK'(req_ready), BLK'(1'b0));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check({tag, ".hold_valid"}, BLK'(rsp_valid), BLK'(1'b1));
            check({tag, ".hold_rdata"}, rsp_rdata, e.rdata);
            check({tag, ".hold_ready"}, BLK'(req_ready), BLK'(1'b0));
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
            check({tag, ".release_valid"}, BLK'(rsp_valid), BLK'(1'b1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench stopped");
    end

    initial begin
        rsp_t e;
        rst_n     = 1'b0;
        prog_busy = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h8000_0010;
        req_wdata = '0;
        req_wstrb = '0;

        // Reset state, with a read presented to show the RAM pins stay quiet.
        #3;
        check("rst.rsp_valid", BLK'(rsp_valid), BLK'(1'b0));
        check("rst.rsp_err", BLK'(rsp_err), BLK'(1'b0));
        check("rst.rsp_rdata", rsp_rdata, BLK'(0));
        check("rst.rd_en", BLK'(ram_rd_en), BLK'(1'b0));
        check("rst.wstrb", BLK'(ram_wstrb), BLK'(0));
        check("rst.ready", BLK'(req_ready), BLK'(1'b1));
        prog_busy = 1'b1;
        #1;
        check("rst.ready_busy", BLK'(req_ready), BLK'(1'b0));
        prog_busy = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Line read: words 4..7.
        do_req("rd4", 1'b0, 32'h8000_0010, '0, '0, AW'(4), 1'b1, '0,
               128'h44444444_33333333_22222222_11111111, 1'b0);
        wait_rsp("rd4", 2, 0);

        // Partial write: only the low word of line 8 changes.
        do_req("wr8", 1'b1, 32'h8000_0020, 128'hCAFEF00D_CAFEF00D_CAFEF00D_DEADBEEF,
               16'h000F, AW'(8), 1'b0, 16'h000F, '0, 1'b0);
        wait_rsp("wr8", 1, 0);

        // Readback through an unaligned address in the same line.
        do_req("rd8", 1'b0, 32'h8000_002C, '0, '0, AW'(8), 1'b1, '0,
               {init_word(11), init_word(10), init_word(9), 32'hDEADBEEF}, 1'b0);
        wait_rsp("rd8", 2, 0);

        // Write with no strobes is still acknowledged.
        do_req("wr_nostrb", 1'b1, 32'h8000_0030, {4{32'h5555_AAAA}}, '0, AW'(12), 1'b0,
               '0, '0, 1'b0);
        wait_rsp("wr_nostrb", 1, 0);

`ifdef RAM_BRIDGE_RANGE_CHECK_EN
        do_req("below", 1'b0, 32'h7FFF_FFF0, '0, '0, AW'(15'h7FFC), 1'b0, '0, '0, 1'b1);
        wait_rsp("below", 1, 0);
        do_req("above", 1'b0, 32'h8002_0000, '0, '0, AW'(0), 1'b0, '0, '0, 1'b1);
        wait_rsp("above", 1, 0);
        do_req("above_wr", 1'b1, 32'h8002_0000, {4{32'h1234_5678}}, 16'hFFFF, AW'(0),
               1'b0, '0, '0, 1'b1);
        wait_rsp("above_wr", 1, 0);
        do_req("last_line", 1'b0, 32'h8001_FFF0, '0, '0, AW'(15'h7FFC), 1'b1, '0,
               init_line(32'h7FFC), 1'b0);
        wait_rsp("last_line", 2, 0);
`else
        // Without range checking the index wraps modulo the RAM depth.
        do_req("wrap_low", 1'b0, 32'h7FFF_FFF0, '0, '0, AW'(15'h7FFC), 1'b1, '0,
               init_line(32'h7FFC), 1'b0);
        wait_rsp("wrap_low", 2, 0);
        do_req("wrap_high", 1'b0, 32'h8002_0000, '0, '0, AW'(0), 1'b1, '0,
               init_line(0), 1'b0);
        wait_rsp("wrap_high", 2, 0);
`endif

        // Consumer stalls for 5 cycles after the response appears.
        do_req("hold", 1'b0, 32'h8000_0010, '0, '0, AW'(4), 1'b1, '0,
               128'h44444444_33333333_22222222_11111111, 1'b0);
        wait_rsp("hold", 2, 5);

        // Programmer takes the RAM while a read is in RD_WAIT.
        do_req("busy", 1'b0, 32'h8000_0010, '0, '0, AW'(4), 1'b1, '0,
               128'h44444444_33333333_22222222_11111111, 1'b0);
        prog_busy = 1'b1;
        wait_rsp("busy", 2, 0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h8000_0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy.blocked_ready", BLK'(req_ready), BLK'(1'b0));
            check("busy.blocked_rd_en", BLK'(ram_rd_en), BLK'(1'b0));
            @(posedge clk);
            #1;
        end
        prog_busy = 1'b0;
        do_req("busy_after", 1'b0, 32'h8000_0010, '0, '0, AW'(4), 1'b1, '0,
               128'h44444444_33333333_22222222_11111111, 1'b0);
        wait_rsp("busy_after", 2, 0);

        // Reset asserted while a read response is pending.
        do_req("rst_resp", 1'b0, 32'h8000_0010, '0, '0, AW'(4), 1'b1, '0,
               128'h44444444_33333333_22222222_11111111, 1'b0);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_resp.valid_before", BLK'(rsp_valid), BLK'(1'b1));
        if (exp_q.size() == 0) bail("rst_resp.queue");
        e = exp_q.pop_front();
        check("rst_resp.rdata_before", rsp_rdata, e.rdata);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_resp.valid_async", BLK'(rsp_valid), BLK'(1'b0));
        check("rst_resp.rdata_async", rsp_rdata, BLK'(0));
        check("rst_resp.err_async", BLK'(rsp_err), BLK'(1'b0));
        check("rst_resp.ready_async", BLK'(req_ready), BLK'(1'b1));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_resp.no_pending", BLK'(rsp_valid), BLK'(1'b0));
            @(posedge clk);
            #1;
        end

        // Normal operation resumes after reset.
        do_req("post_rst", 1'b0, 32'h8000_0010, '0, '0, AW'(4), 1'b1, '0,
               128'h44444444_33333333_22222222_11111111, 1'b0);
        wait_rsp("post_rst", 2, 0);

        check("scoreboard_empty", BLK'(exp_q.size()), BLK'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
